// File: rtl/branch_predictor_cp4_if.sv
// rtl/branch_predictor_cp4_if.sv - guess/check port bundle for the branch predictor
interface branch_predictor_cp4_if #(
  parameter int PC_W = 32
);
  logic            bp_en;
  logic [PC_W-1:0] pc_guess;
  logic            is_br_guess;
  logic            br_pred_taken;
  logic            pred_hit;
  logic [PC_W-1:0] pc_check;
  logic            is_br_check;
  logic            br_taken_check;
  logic            br_pred_check;
  logic            br_mispredict;

  modport master (
    output bp_en, pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check, br_pred_check,
    input  br_pred_taken, pred_hit, br_mispredict
  );

  modport slave (
    input  bp_en, pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check, br_pred_check,
    output br_pred_taken, pred_hit, br_mispredict
  );
endinterface

// File: rtl/branch_predictor_cp4.sv
// rtl/branch_predictor_cp4.sv - direct-mapped tagged 2-bit-counter BHT
// Optional BP_STATS_EN adds branch/mispredict event counters.
module branch_predictor_cp4 #(
  parameter int LINES = 32,
  parameter int PC_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predictor_cp4_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid   [LINES];
  logic [1:0]       cnt     [LINES];
  logic [TAG_W-1:0] tag_mem [LINES];

  logic [IDX_W-1:0] idx_g, idx_c;
  logic [TAG_W-1:0] tag_g, tag_c;
  logic             hit_c;
  logic             do_update;
  logic [1:0]       cnt_next;
  logic             unused_pc_lsbs;

  assign idx_g = bp.pc_guess[IDX_W+1:2];
  assign tag_g = bp.pc_guess[PC_W-1:IDX_W+2];
  assign idx_c = bp.pc_check[IDX_W+1:2];
  assign tag_c = bp.pc_check[PC_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{bp.pc_guess[1:0], bp.pc_check[1:0]};

  // Guess reads the table state before this cycle's update; no bypass.
  assign bp.pred_hit      = valid[idx_g] & (tag_mem[idx_g] == tag_g);
  assign bp.br_pred_taken = bp.bp_en & bp.is_br_guess & bp.pred_hit & cnt[idx_g][1];
  assign bp.br_mispredict = bp.is_br_check & (bp.br_taken_check != bp.br_pred_check);

  assign hit_c     = valid[idx_c] & (tag_mem[idx_c] == tag_c);
  assign do_update = bp.bp_en & bp.is_br_check;

  always_comb begin
    cnt_next = cnt[idx_c];
    if (!hit_c) begin
      cnt_next = bp.br_taken_check ? 2'b10 : 2'b01;
    end else if (bp.br_taken_check) begin
      if (cnt[idx_c] != 2'b11) cnt_next = cnt[idx_c] + 2'b01;
    end else begin
      if (cnt[idx_c] != 2'b00) cnt_next = cnt[idx_c] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) begin
        valid[i] <= 1'b0;
        cnt[i]   <= 2'b00;
      end
    end else if (do_update) begin
      valid[idx_c] <= 1'b1;
      cnt[idx_c]   <= cnt_next;
    end
  end

  // Tags are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (do_update && rst_n) begin
      tag_mem[idx_c] <= tag_c;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (bp.is_br_check)   stat_branches    <= stat_branches + 32'd1;
      if (bp.br_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor_cp4.sv
// tb/tb_branch_predictor_cp4.sv - directed self-checking bench for branch_predictor_cp4
module tb_branch_predictor_cp4;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_br;
  int   exp_mp;

  branch_predictor_cp4_if #(.PC_W(32)) bp_if ();

`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor_cp4 #(.LINES(32), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if.slave)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_guess(input logic [31:0] pc, input logic is_br);
    bp_if.pc_guess    = pc;
    bp_if.is_br_guess = is_br;
  endtask

  task automatic set_check(input logic [31:0] pc, input logic is_br, input logic taken, input logic pred);
    bp_if.pc_check       = pc;
    bp_if.is_br_check    = is_br;
    bp_if.br_taken_check = taken;
    bp_if.br_pred_check  = pred;
  endtask

  // Advance one clock; the stats model follows the bench's own inputs.
  task automatic tick();
    if (rst_n && bp_if.is_br_check) begin
      exp_br++;
      if (bp_if.br_taken_check != bp_if.br_pred_check) exp_mp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken);
    set_check(pc, 1'b1, taken, taken);
    tick();
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_guess(input string tag, input logic [31:0] pc, input logic hit, input logic taken);
    set_guess(pc, 1'b1);
    #1;
    check_eq({tag, "_hit"}, {31'd0, bp_if.pred_hit}, {31'd0, hit});
    check_eq({tag, "_pred"}, {31'd0, bp_if.br_pred_taken}, {31'd0, taken});
  endtask

  localparam logic [31:0] PC_A     = 32'h1000_0040;
  localparam logic [31:0] PC_ALIAS = 32'h1000_00C0;

  initial begin
    checks = 0; failures = 0; exp_br = 0; exp_mp = 0;
    rst_n = 1'b0;
    bp_if.bp_en = 1'b1;
    set_guess(PC_A, 1'b1);
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("rst_hit", {31'd0, bp_if.pred_hit}, 32'd0);
    check_eq("rst_pred", {31'd0, bp_if.br_pred_taken}, 32'd0);
    check_eq("rst_misp", {31'd0, bp_if.br_mispredict}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_guess("post_rst", PC_A, 1'b0, 1'b0);

    // First resolve allocates at weak-taken; carried prediction 0 flags.
    set_check(PC_A, 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("alloc_misp", {31'd0, bp_if.br_mispredict}, 32'd1);
    tick();
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
    expect_guess("alloc", PC_A, 1'b1, 1'b1);

    for (int i = 0; i < 3; i++) train(PC_A, 1'b1);
    expect_guess("sat_t", PC_A, 1'b1, 1'b1);
    set_check(PC_A, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("nt_misp", {31'd0, bp_if.br_mispredict}, 32'd1);
    tick();
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
    expect_guess("nt1", PC_A, 1'b1, 1'b1);
    train(PC_A, 1'b0);
    expect_guess("nt2", PC_A, 1'b1, 1'b0);

    // Same-cycle collision: guess sees pre-update counter 01.
    set_check(PC_A, 1'b1, 1'b1, 1'b0);
    expect_guess("coll_same", PC_A, 1'b1, 1'b0);
    tick();
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
    expect_guess("coll_next", PC_A, 1'b1, 1'b1);

    set_guess(PC_A, 1'b0);
    #1;
    check_eq("notbr_pred", {31'd0, bp_if.br_pred_taken}, 32'd0);
    check_eq("notbr_hit", {31'd0, bp_if.pred_hit}, 32'd1);

    // Disabled: mispredict still flags, no prediction, no training.
    bp_if.bp_en = 1'b0;
    set_guess(PC_A, 1'b1);
    set_check(PC_A, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("dis_misp", {31'd0, bp_if.br_mispredict}, 32'd1);
    check_eq("dis_pred", {31'd0, bp_if.br_pred_taken}, 32'd0);
    tick();
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
    bp_if.bp_en = 1'b1;
    expect_guess("dis_keep", PC_A, 1'b1, 1'b1);

    set_check(PC_A, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("nochk_misp", {31'd0, bp_if.br_mispredict}, 32'd0);
    tick();
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
    expect_guess("nochk_keep", PC_A, 1'b1, 1'b1);

    // Aliasing on idx 0x10.
    train(PC_A, 1'b1);
    train(PC_ALIAS, 1'b0);
    expect_guess("alias_a", PC_A, 1'b0, 1'b0);
    expect_guess("alias_b", PC_ALIAS, 1'b1, 1'b0);
    expect_guess("lsb_ign", 32'h1000_00C3, 1'b1, 1'b0);
    train(PC_ALIAS, 1'b1);
    expect_guess("alias_b_t", PC_ALIAS, 1'b1, 1'b1);
    expect_guess("other_idx", 32'h1000_0044, 1'b0, 1'b0);

    // Saturation at strong-not-taken.
    for (int i = 0; i < 3; i++) train(PC_ALIAS, 1'b0);
    train(PC_ALIAS, 1'b1);
    expect_guess("sat_nt", PC_ALIAS, 1'b1, 1'b0);
    train(PC_ALIAS, 1'b1);
    expect_guess("sat_nt_up", PC_ALIAS, 1'b1, 1'b1);

`ifdef BP_STATS_EN
    check_eq("stat_br", stat_branches, exp_br);
    check_eq("stat_mp", stat_mispredicts, exp_mp);
`endif

    // Async reset mid-update discards the pending write and clears the table.
    set_check(PC_A, 1'b1, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_hit", {31'd0, bp_if.pred_hit}, 32'd0);
    check_eq("mid_rst_misp", {31'd0, bp_if.br_mispredict}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_check(32'h0, 1'b0, 1'b0, 1'b0);
    exp_br = 0; exp_mp = 0;
    expect_guess("mid_rst_a", PC_A, 1'b0, 1'b0);
    expect_guess("mid_rst_b", PC_ALIAS, 1'b0, 1'b0);
`ifdef BP_STATS_EN
    check_eq("stat_rst", stat_branches, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
